stack_op_sequencer: RTL and testbench



---
 rtl/stack_op_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// rtl/stack_op_sequencer.sv - Moore control sequencer for the stack/TOS datapath
module stack_op_sequencer #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [1:0]            cmd_src,
  input  logic [ADDR_WIDTH-1:0] ret_tos,
  output logic                  done,
  output logic                  err,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic [2:0]            sel_mux_stack,
  output logic                  ctrl_reg_read_stack,
  output logic                  ctrl_reg_write_stack,
  output logic                  ctrl_reg_read_mem,
  output logic                  ctrl_reg_write_mem,
  output logic                  sel_mux_tos,
  output logic                  ctrl_reg_tos,
  output logic                  sel_tos_updater,
  output logic                  ctrl_stack,
  output logic                  ctrl_mem_ext
);

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_POP   = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_DUP   = 3'b100;
  localparam logic [2:0] OP_RET   = 3'b101;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] PU_LATCH = 4'd1;
  localparam logic [3:0] PU_WRITE = 4'd2;
  localparam logic [3:0] PO_WAIT  = 4'd3;
  localparam logic [3:0] PO_CAP   = 4'd4;
  localparam logic [3:0] LD_WAIT  = 4'd5;
  localparam logic [3:0] LD_CAP   = 4'd6;
  localparam logic [3:0] ST_WAIT  = 4'd7;
  localparam logic [3:0] ST_CAP   = 4'd8;
  localparam logic [3:0] ST_WRITE = 4'd9;
  localparam logic [3:0] DU_WAIT  = 4'd10;
  localparam logic [3:0] DU_CAP   = 4'd11;
  localparam logic [3:0] RT       = 4'd12;
  localparam logic [3:0] ERR      = 4'd13;

  logic [3:0]            state;
  logic [2:0]            src_q;
  logic [ADDR_WIDTH-1:0] ret_q;
  logic                  reject;
  logic                  accept;

  assign cmd_ready = (state == IDLE) & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  assign empty     = (depth == '0);
  assign full      = &depth;

  // Guard check against the occupancy seen at the accept edge
  always_comb begin
    reject = 1'b0;
    case (cmd_op)
      OP_PUSH, OP_LOAD:  reject = full;
      OP_POP, OP_STORE:  reject = empty;
      OP_DUP:            reject = empty | full;
      OP_RET:            reject = 1'b0;
      default:           reject = 1'b1;
    endcase
  end

  // State, shadow depth and accept-time captures of source select and return TOS
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      depth <= '0;
      src_q <= 3'b000;
      ret_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ret_q <= ret_tos;
            if (reject) begin
              state <= ERR;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  src_q <= {1'b0, cmd_src};
                  state <= PU_LATCH;
                end
                OP_POP:   state <= PO_WAIT;
                OP_LOAD: begin
                  src_q <= 3'b001;
                  state <= LD_WAIT;
                end
                OP_STORE: state <= ST_WAIT;
                OP_DUP: begin
                  src_q <= 3'b100;
                  state <= DU_WAIT;
                end
                default:  state <= RT;
              endcase
            end
          end
        end
        PU_LATCH: begin
          depth <= depth + ADDR_WIDTH'(1);
          state <= PU_WRITE;
        end
        PO_WAIT:  state <= PO_CAP;
        PO_CAP: begin
          depth <= depth - ADDR_WIDTH'(1);
          state <= IDLE;
        end
        LD_WAIT:  state <= LD_CAP;
        LD_CAP:   state <= PU_LATCH;
        ST_WAIT:  state <= ST_CAP;
        ST_CAP: begin
          depth <= depth - ADDR_WIDTH'(1);
          state <= ST_WRITE;
        end
        DU_WAIT:  state <= DU_CAP;
        DU_CAP:   state <= PU_LATCH;
        RT: begin
          depth <= ret_q;
          state <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

  // Control strobes decoded purely from the state register
  always_comb begin
    sel_mux_stack        = 3'b000;
    ctrl_reg_read_stack  = 1'b0;
    ctrl_reg_write_stack = 1'b0;
    ctrl_reg_read_mem    = 1'b0;
    ctrl_reg_write_mem   = 1'b0;
    sel_mux_tos          = 1'b0;
    ctrl_reg_tos         = 1'b0;
    sel_tos_updater      = 1'b0;
    ctrl_stack           = 1'b0;
    ctrl_mem_ext         = 1'b0;
    done                 = 1'b0;
    err                  = 1'b0;
    case (state)
      PU_LATCH: begin
        ctrl_reg_write_stack = 1'b1;
        sel_mux_stack        = src_q;
        ctrl_reg_tos         = 1'b1;
      end
      PU_WRITE: begin
        ctrl_stack = 1'b1;
        done       = 1'b1;
      end
      PO_CAP: begin
        ctrl_reg_read_stack = 1'b1;
        ctrl_reg_tos        = 1'b1;
        sel_tos_updater     = 1'b1;
        done                = 1'b1;
      end
      LD_CAP:   ctrl_reg_read_mem = 1'b1;
      ST_CAP: begin
        ctrl_reg_write_mem = 1'b1;
        ctrl_reg_tos       = 1'b1;
        sel_tos_updater    = 1'b1;
      end
      ST_WRITE: begin
        ctrl_mem_ext = 1'b1;
        done         = 1'b1;
      end
      DU_CAP:   ctrl_reg_read_stack = 1'b1;
      RT: begin
        sel_mux_tos  = 1'b1;
        ctrl_reg_tos = 1'b1;
        done         = 1'b1;
      end
      ERR:      err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb/tb_stack_op_sequencer.sv - directed self-checking bench for stack_op_sequencer
module tb_stack_op_sequencer;

  localparam int AW = 12;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [1:0]    cmd_src;
  logic [AW-1:0] ret_tos;
  logic          done, err, empty, full;
  logic [AW-1:0] depth;
  logic [2:0]    sel_mux_stack;
  logic          ctrl_reg_read_stack, ctrl_reg_write_stack, ctrl_reg_read_mem, ctrl_reg_write_mem;
  logic          sel_mux_tos, ctrl_reg_tos, sel_tos_updater, ctrl_stack, ctrl_mem_ext;

  int tests = 0;
  int fails = 0;

  stack_op_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .ret_tos(ret_tos),
    .done(done), .err(err), .empty(empty), .full(full), .depth(depth),
    .sel_mux_stack(sel_mux_stack),
    .ctrl_reg_read_stack(ctrl_reg_read_stack), .ctrl_reg_write_stack(ctrl_reg_write_stack),
    .ctrl_reg_read_mem(ctrl_reg_read_mem), .ctrl_reg_write_mem(ctrl_reg_write_mem),
    .sel_mux_tos(sel_mux_tos), .ctrl_reg_tos(ctrl_reg_tos), .sel_tos_updater(sel_tos_updater),
    .ctrl_stack(ctrl_stack), .ctrl_mem_ext(ctrl_mem_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: [13]rd_stk [12]wr_stk [11]rd_mem [10]wr_mem [9]mux_tos [8]tos [7]upd
  //              [6]stack [5]mem_ext [4]done [3]err [2:0]sel_mux_stack
  wire [13:0] ctl = {ctrl_reg_read_stack, ctrl_reg_write_stack, ctrl_reg_read_mem,
                     ctrl_reg_write_mem, sel_mux_tos, ctrl_reg_tos, sel_tos_updater,
                     ctrl_stack, ctrl_mem_ext, done, err, sel_mux_stack};

  // Issue one command from a negedge; returns at the negedge after the accept edge (cycle +1).
  // Inputs are scrambled after acceptance to show they are only sampled at accept.
  task automatic issue(input logic [2:0] op, input logic [1:0] src, input logic [AW-1:0] rt);
    int waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_ready cmd_ready=%b expected 1 after %0d cycles", cmd_ready, waited);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; ret_tos = rt;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'b111; cmd_src = 2'b01; ret_tos = 12'h5A5;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_src = 2'b00; ret_tos = '0;
    repeat (3) @(negedge clk);
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
    tests++; if (depth !== 12'h000) begin fails++; $display("FAIL reset_depth got=%h exp=000", depth); end
    tests++; if ({empty, full} !== 2'b10) begin fails++; $display("FAIL reset_flags empty,full got=%b exp=10", {empty, full}); end
    tests++; if (ctl !== 14'h0000) begin fails++; $display("FAIL reset_ctl got=%h exp=0000", ctl); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_push();
    issue(3'b000, 2'd0, '0);
    tests++; if (ctl !== 14'h1100) begin fails++; $display("FAIL push_latch ctl got=%h exp=1100", ctl); end
    tests++; if (depth !== 12'h000) begin fails++; $display("FAIL push_latch_depth got=%h exp=000", depth); end
    @(negedge clk);
    tests++; if (ctl !== 14'h0050) begin fails++; $display("FAIL push_write ctl got=%h exp=0050", ctl); end
    tests++; if ({depth, empty} !== {12'h001, 1'b0}) begin fails++; $display("FAIL push_depth depth=%h empty=%b exp 001/0", depth, empty); end
    @(negedge clk);
    tests++; if ({cmd_ready, ctl} !== {1'b1, 14'h0000}) begin fails++; $display("FAIL push_idle ready,ctl got=%b,%h exp=1,0000", cmd_ready, ctl); end
  endtask

  task automatic test_push_pop();
    issue(3'b000, 2'd3, '0);
    tests++; if (ctl !== 14'h1103) begin fails++; $display("FAIL push_arg_latch ctl got=%h exp=1103", ctl); end
    @(negedge clk);
    tests++; if (depth !== 12'h002) begin fails++; $display("FAIL push2_depth got=%h exp=002", depth); end
    issue(3'b001, 2'd0, '0);
    tests++; if (ctl !== 14'h0000) begin fails++; $display("FAIL pop_wait ctl got=%h exp=0000", ctl); end
    @(negedge clk);
    tests++; if (ctl !== 14'h2190) begin fails++; $display("FAIL pop_cap ctl got=%h exp=2190", ctl); end
    tests++; if (depth !== 12'h002) begin fails++; $display("FAIL pop_cap_depth got=%h exp=002", depth); end
    @(negedge clk);
    tests++; if (depth !== 12'h001) begin fails++; $display("FAIL pop_depth got=%h exp=001", depth); end
    issue(3'b001, 2'd0, '0);
    repeat (2) @(negedge clk);
    tests++; if ({depth, empty} !== {12'h000, 1'b1}) begin fails++; $display("FAIL pop_empty depth=%h empty=%b exp 000/1", depth, empty); end
  endtask

  task automatic test_load_store();
    issue(3'b010, 2'd2, '0);
    tests++; if (ctl !== 14'h0000) begin fails++; $display("FAIL load_wait ctl got=%h exp=0000", ctl); end
    @(negedge clk);
    tests++; if (ctl !== 14'h0800) begin fails++; $display("FAIL load_cap ctl got=%h exp=0800", ctl); end
    @(negedge clk);
    tests++; if (ctl !== 14'h1101) begin fails++; $display("FAIL load_latch ctl got=%h exp=1101", ctl); end
    @(negedge clk);
    tests++; if ({ctl, depth} !== {14'h0050, 12'h001}) begin fails++; $display("FAIL load_write ctl=%h depth=%h exp 0050/001", ctl, depth); end
    issue(3'b011, 2'd0, '0);
    tests++; if (ctl !== 14'h0000) begin fails++; $display("FAIL store_wait ctl got=%h exp=0000", ctl); end
    @(negedge clk);
    tests++; if ({ctl, depth} !== {14'h0580, 12'h001}) begin fails++; $display("FAIL store_cap ctl=%h depth=%h exp 0580/001", ctl, depth); end
    @(negedge clk);
    tests++; if ({ctl, depth} !== {14'h0030, 12'h000}) begin fails++; $display("FAIL store_write ctl=%h depth=%h exp 0030/000", ctl, depth); end
  endtask

  task automatic test_dup();
    issue(3'b000, 2'd2, '0);
    tests++; if (ctl !== 14'h1102) begin fails++; $display("FAIL push_ret_latch ctl got=%h exp=1102", ctl); end
    @(negedge clk);
    issue(3'b100, 2'd3, '0);
    tests++; if (ctl !== 14'h0000) begin fails++; $display("FAIL dup_wait ctl got=%h exp=0000", ctl); end
    @(negedge clk);
    tests++; if (ctl !== 14'h2000) begin fails++; $display("FAIL dup_cap ctl got=%h exp=2000", ctl); end
    @(negedge clk);
    tests++; if (ctl !== 14'h1104) begin fails++; $display("FAIL dup_latch ctl got=%h exp=1104", ctl); end
    @(negedge clk);
    tests++; if ({ctl, depth} !== {14'h0050, 12'h002}) begin fails++; $display("FAIL dup_write ctl=%h depth=%h exp 0050/002", ctl, depth); end
  endtask

  task automatic test_errors();
    pulse_reset();
    issue(3'b100, 2'd0, '0);
    tests++; if ({ctl, depth} !== {14'h0008, 12'h000}) begin fails++; $display("FAIL dup_empty ctl=%h depth=%h exp 0008/000", ctl, depth); end
    @(negedge clk);
    tests++; if ({cmd_ready, ctl} !== {1'b1, 14'h0000}) begin fails++; $display("FAIL err_idle ready,ctl got=%b,%h exp=1,0000", cmd_ready, ctl); end
    issue(3'b001, 2'd0, '0);
    tests++; if ({ctl, depth} !== {14'h0008, 12'h000}) begin fails++; $display("FAIL pop_empty_err ctl=%h depth=%h exp 0008/000", ctl, depth); end
    issue(3'b011, 2'd0, '0);
    tests++; if (ctl !== 14'h0008) begin fails++; $display("FAIL store_empty_err ctl got=%h exp=0008", ctl); end
    issue(3'b110, 2'd0, '0);
    tests++; if (ctl !== 14'h0008) begin fails++; $display("FAIL illegal_110 ctl got=%h exp=0008", ctl); end
    issue(3'b111, 2'd0, '0);
    tests++; if (ctl !== 14'h0008) begin fails++; $display("FAIL illegal_111 ctl got=%h exp=0008", ctl); end
  endtask

  task automatic test_ret_full();
    issue(3'b101, 2'd0, 12'hFFF);
    tests++; if ({ctl, depth} !== {14'h0310, 12'h000}) begin fails++; $display("FAIL ret_rt ctl=%h depth=%h exp 0310/000", ctl, depth); end
    @(negedge clk);
    tests++; if ({depth, full, empty} !== {12'hFFF, 2'b10}) begin fails++; $display("FAIL ret_full depth=%h full=%b empty=%b exp FFF/1/0", depth, full, empty); end
    issue(3'b000, 2'd0, '0);
    tests++; if ({ctl, depth} !== {14'h0008, 12'hFFF}) begin fails++; $display("FAIL push_full ctl=%h depth=%h exp 0008/FFF", ctl, depth); end
    issue(3'b010, 2'd0, '0);
    tests++; if (ctl !== 14'h0008) begin fails++; $display("FAIL load_full ctl got=%h exp=0008", ctl); end
    issue(3'b100, 2'd0, '0);
    tests++; if (ctl !== 14'h0008) begin fails++; $display("FAIL dup_full ctl got=%h exp=0008", ctl); end
    issue(3'b001, 2'd0, '0);
    repeat (2) @(negedge clk);
    tests++; if (depth !== 12'hFFE) begin fails++; $display("FAIL pop_from_full depth got=%h exp=FFE", depth); end
    issue(3'b101, 2'd0, 12'h000);
    @(negedge clk);
    tests++; if ({depth, empty} !== {12'h000, 1'b1}) begin fails++; $display("FAIL ret_zero depth=%h empty=%b exp 000/1", depth, empty); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_src = 2'd0;
    @(negedge clk);
    tests++; if (ctl !== 14'h1100) begin fails++; $display("FAIL b2b_latch1 ctl got=%h exp=1100", ctl); end
    @(negedge clk);
    tests++; if (ctl !== 14'h0050) begin fails++; $display("FAIL b2b_write1 ctl got=%h exp=0050", ctl); end
    @(negedge clk);
    tests++; if ({cmd_ready, ctl} !== {1'b1, 14'h0000}) begin fails++; $display("FAIL b2b_gap ready,ctl got=%b,%h exp=1,0000", cmd_ready, ctl); end
    @(negedge clk);
    tests++; if (ctl !== 14'h1100) begin fails++; $display("FAIL b2b_latch2 ctl got=%h exp=1100", ctl); end
    @(negedge clk);
    cmd_valid = 1'b0;
    tests++; if ({ctl, depth} !== {14'h0050, 12'h002}) begin fails++; $display("FAIL b2b_write2 ctl=%h depth=%h exp 0050/002", ctl, depth); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    issue(3'b010, 2'd0, '0);
    @(negedge clk);
    tests++; if (ctl !== 14'h0800) begin fails++; $display("FAIL mid_ld_cap ctl got=%h exp=0800", ctl); end
    reset = 1'b1;
    @(negedge clk);
    tests++; if ({ctl, depth, cmd_ready} !== {14'h0000, 12'h000, 1'b0}) begin fails++; $display("FAIL mid_reset ctl=%h depth=%h ready=%b exp 0000/000/0", ctl, depth, cmd_ready); end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || ctl != 14'h0000) dones++;
    end
    tests++; if (dones !== 0) begin fails++; $display("FAIL mid_no_activity cycles_active got=%0d exp=0", dones); end
    tests++; if ({cmd_ready, depth} !== {1'b1, 12'h000}) begin fails++; $display("FAIL mid_after ready=%b depth=%h exp 1/000", cmd_ready, depth); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_push_pop();
    test_load_store();
    test_dup();
    test_errors();
    test_ret_full();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
